// File: rtl/axi_burst_txn_scheduler_pkg.sv
// Shared types and helpers for the M00_AXI burst transaction scheduler.
package axi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } sched_state_t;

  // Widest requester set any instance may use; pickers work on this width.
  localparam int MAX_REQ             = 8;
  localparam int TIMEOUT_CYCLES_DFLT = 4096;
  localparam int CNT_W               = $clog2(TIMEOUT_CYCLES_DFLT);

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req scanning upward from ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input logic [3:0]         n);
    rr_pick_t   r;
    logic [3:0] c;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      // ptr < n and i < n, so one subtraction brings c back into range
      c = {1'b0, ptr} + 4'(i);
      if (c >= n) begin
        c = c - n;
      end else begin
        c = c;
      end
      if ((4'(i) < n) && !r.found && req[c[2:0]]) begin
        r.found = 1'b1;
        r.idx   = c[2:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_txn_scheduler_arb.sv
// Purely combinational round-robin picker: request vector and pointer in,
// one-hot grant plus binary index out.
module rr_arbiter_comb
  import axi_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  rr_pick_t           pick;

  // Widen inputs to the picker width and decode the chosen requester.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    ptr_ext        = 3'd0;
    ptr_ext[IW-1:0] = ptr;
    pick           = rr_pick(req_ext, ptr_ext, 4'(N));
    found          = pick.found;
    idx            = IW'(pick.idx);
    grant          = '0;
    if (pick.found) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/axi_burst_txn_scheduler.sv
// Shares one M00_AXI burst engine between NUM_REQ requesters: round-robin
// grant, init pulse, wait for a fresh done edge or a watchdog timeout, then a
// one-cycle response to the requester that issued the transaction.
module axi_burst_txn_scheduler
  import axi_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int INIT_PULSE_W   = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      txn_init,
  output logic [ADDR_W-1:0]         txn_addr,
  output logic                      txn_wr,
  input  logic                      txn_done,
  input  logic                      txn_error,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_error,
  output logic                      resp_timeout,
  output logic                      busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_grant
);

  localparam int GW     = $clog2(NUM_REQ);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] CNT_LAST   = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]        PULSE_LAST = 2'(INIT_PULSE_W - 1);
  localparam logic [GW-1:0]     PTR_LAST   = GW'(NUM_REQ - 1);

  sched_state_t        state_q, state_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]       cur_grant_q, cur_grant_d;
  logic [TCNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          pulse_q, pulse_d;
  logic                done_q, done_d;
  logic                txn_init_q, txn_init_d;
  logic [ADDR_W-1:0]   txn_addr_q, txn_addr_d;
  logic                txn_wr_q, txn_wr_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic                resp_error_q, resp_error_d;
  logic                resp_timeout_q, resp_timeout_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [GW-1:0]       arb_idx;
  logic                arb_found;
  logic                any_req;
  logic                completion;

  rr_arbiter_comb #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  assign any_req = |req_valid;
  // A done level still high from the previous transaction must not count,
  // so only a rising edge seen from the second WAIT cycle on completes.
  assign completion = txn_done & ~done_q & (cnt_q != '0);

  // Acceptance strobe is tied to the ARB cycle in which the grant is decided.
  assign req_ready    = (state_q == ARB) ? arb_grant : '0;
  assign txn_init     = txn_init_q;
  assign txn_addr     = txn_addr_q;
  assign txn_wr       = txn_wr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_error   = resp_error_q;
  assign resp_timeout = resp_timeout_q;
  assign busy         = busy_q;
  assign cur_grant    = cur_grant_q;

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cur_grant_d    = cur_grant_q;
    cnt_d          = cnt_q;
    pulse_d        = pulse_q;
    done_d         = txn_done;
    txn_init_d     = 1'b0;
    txn_addr_d     = txn_addr_q;
    txn_wr_d       = txn_wr_q;
    resp_valid_d   = '0;
    resp_error_d   = 1'b0;
    resp_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (arb_found) begin
          cur_grant_d = arb_idx;
          txn_addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
          txn_wr_d    = req_wr[arb_idx];
          rr_ptr_d    = (arb_idx == PTR_LAST) ? '0 : arb_idx + GW'(1);
          pulse_d     = 2'd0;
          txn_init_d  = 1'b1;
          state_d     = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        if (pulse_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          pulse_d    = pulse_q + 2'd1;
          txn_init_d = 1'b1;
        end
      end
      WAIT: begin
        if (completion) begin
          resp_valid_d[cur_grant_q] = 1'b1;
          resp_error_d              = txn_error;
          state_d                   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_d[cur_grant_q] = 1'b1;
          resp_error_d              = 1'b1;
          resp_timeout_d            = 1'b1;
          state_d                   = RESP;
        end else begin
          cnt_d = cnt_q + TCNT_W'(1);
        end
      end
      RESP: begin
        if (any_req) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      cur_grant_q    <= '0;
      cnt_q          <= '0;
      pulse_q        <= 2'd0;
      done_q         <= 1'b0;
      txn_init_q     <= 1'b0;
      txn_addr_q     <= '0;
      txn_wr_q       <= 1'b0;
      resp_valid_q   <= '0;
      resp_error_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cur_grant_q    <= cur_grant_d;
      cnt_q          <= cnt_d;
      pulse_q        <= pulse_d;
      done_q         <= done_d;
      txn_init_q     <= txn_init_d;
      txn_addr_q     <= txn_addr_d;
      txn_wr_q       <= txn_wr_d;
      resp_valid_q   <= resp_valid_d;
      resp_error_q   <= resp_error_d;
      resp_timeout_q <= resp_timeout_d;
      busy_q         <= busy_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_txn_scheduler.sv
// Directed bench for axi_burst_txn_scheduler (4 requesters, 16-cycle watchdog).
module tb_axi_burst_txn_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int ADDR_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int INIT_PULSE_W   = 1;

  logic                      ACLK;
  logic                      ARESET;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      txn_init;
  logic [ADDR_W-1:0]         txn_addr;
  logic                      txn_wr;
  logic                      txn_done;
  logic                      txn_error;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_error;
  logic                      resp_timeout;
  logic                      busy;
  logic [1:0]                cur_grant;

  int n_checks;
  int n_fail;

  logic [31:0] exp_addr [4];

  axi_burst_txn_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .INIT_PULSE_W   (INIT_PULSE_W)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .txn_init     (txn_init),
    .txn_addr     (txn_addr),
    .txn_wr       (txn_wr),
    .txn_done     (txn_done),
    .txn_error    (txn_error),
    .resp_valid   (resp_valid),
    .resp_error   (resp_error),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .cur_grant    (cur_grant)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_resp(input int max_cyc, output int cyc);
    cyc = 0;
    while (resp_valid == 4'b0000 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    chk("resp_seen", 64'(resp_valid != 4'b0000), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int exp_g;
    int got_g;
    int prev_g;
    logic [3:0] seen;

    n_checks = 0;
    n_fail   = 0;
    exp_addr[0] = 32'h1000_0000;
    exp_addr[1] = 32'h2000_0000;
    exp_addr[2] = 32'h4000_0000;
    exp_addr[3] = 32'h8000_0000;
    ARESET    = 1'b1;
    req_valid = 4'b0000;
    req_wr    = 4'b1100;
    req_addr  = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
    txn_done  = 1'b0;
    txn_error = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_init", 64'(txn_init), 64'd0);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    chk("rst_addr", 64'(txn_addr), 64'd0);
    chk("rst_grant", 64'(cur_grant), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    ARESET = 1'b0;
    tick();

    // single requester 2, write, clean completion
    req_valid = 4'b0100;
    tick();
    chk("t1_ready", 64'(req_ready), 64'h4);
    chk("t1_init_early", 64'(txn_init), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_init", 64'(txn_init), 64'd1);
    chk("t1_addr", 64'(txn_addr), 64'h4000_0000);
    chk("t1_wr", 64'(txn_wr), 64'd1);
    chk("t1_grant", 64'(cur_grant), 64'd2);
    chk("t1_ready_off", 64'(req_ready), 64'd0);
    req_valid = 4'b0000;
    tick();
    chk("t1_init_1cyc", 64'(txn_init), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    txn_done = 1'b1;
    wait_resp(10, cyc);
    chk("t1_resp_lat", 64'(cyc), 64'd1);
    chk("t1_resp", 64'(resp_valid), 64'h4);
    chk("t1_err", 64'(resp_error), 64'd0);
    chk("t1_to", 64'(resp_timeout), 64'd0);
    tick();
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_resp_1cyc", 64'(resp_valid), 64'd0);

    // engine error on requester 0 (pointer is 3, wraps to 0)
    txn_done  = 1'b0;
    req_valid = 4'b0001;
    tick();
    chk("t2_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    chk("t2_addr", 64'(txn_addr), 64'h1000_0000);
    chk("t2_wr", 64'(txn_wr), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    txn_done  = 1'b1;
    txn_error = 1'b1;
    wait_resp(10, cyc);
    chk("t2_resp", 64'(resp_valid), 64'h1);
    chk("t2_err", 64'(resp_error), 64'd1);
    chk("t2_to", 64'(resp_timeout), 64'd0);
    txn_error = 1'b0;
    tick();

    // stale done level stays high across a new launch on requester 1
    req_valid = 4'b0010;
    tick();
    chk("t3_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    seen = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | resp_valid;
    end
    chk("t3_no_stale", 64'(seen), 64'd0);
    txn_done = 1'b0;
    tick(); tick();
    txn_done = 1'b1;
    wait_resp(10, cyc);
    chk("t3_resp", 64'(resp_valid), 64'h2);
    chk("t3_err", 64'(resp_error), 64'd0);
    txn_done = 1'b0;
    tick();

    // watchdog timeout on requester 3, engine silent
    req_valid = 4'b1000;
    tick();
    chk("t4_ready", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    wait_resp(40, cyc);
    chk("t4_resp_lat", 64'(cyc), 64'd16);
    chk("t4_resp", 64'(resp_valid), 64'h8);
    chk("t4_err", 64'(resp_error), 64'd1);
    chk("t4_to", 64'(resp_timeout), 64'd1);
    tick();
    chk("t4_busy_drop", 64'(busy), 64'd0);

    // contention: all four held high for eight transactions
    req_valid = 4'b1111;
    prev_g = -1;
    for (int t = 0; t < 8; t++) begin
      exp_g = t % 4;
      cyc = 0;
      while (req_ready == 4'b0000 && cyc < 10) begin
        tick();
        cyc++;
      end
      chk($sformatf("t5_ready_%0d", t), 64'(req_ready), 64'(4'b0001 << exp_g));
      got_g = -1;
      for (int k = 0; k < 4; k++) begin
        if (req_ready[k]) got_g = k;
      end
      chk($sformatf("t5_no_repeat_%0d", t), 64'(got_g != prev_g), 64'd1);
      prev_g = got_g;
      tick();
      chk($sformatf("t5_addr_%0d", t), 64'(txn_addr), 64'(exp_addr[exp_g]));
      txn_done = 1'b0;
      if (t == 7) req_valid = 4'b0000;
      tick(); tick(); tick();
      txn_done = 1'b1;
      wait_resp(10, cyc);
      chk($sformatf("t5_resp_%0d", t), 64'(resp_valid), 64'(4'b0001 << exp_g));
    end
    tick();
    chk("t5_idle", 64'(busy), 64'd0);

    // reset in WAIT after granting requester 1 (pointer would be 2)
    req_valid = 4'b0010;
    tick(); tick();
    req_valid = 4'b0000;
    txn_done  = 1'b0;
    tick(); tick(); tick();
    chk("t6_in_wait", 64'(busy), 64'd1);
    ARESET = 1'b1;
    tick();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_init", 64'(txn_init), 64'd0);
    chk("t6_resp", 64'(resp_valid), 64'd0);
    chk("t6_grant", 64'(cur_grant), 64'd0);
    chk("t6_addr", 64'(txn_addr), 64'd0);
    ARESET    = 1'b0;
    txn_done  = 1'b1;
    req_valid = 4'b0110;
    tick();
    chk("t6_ptr_reset", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    txn_done  = 1'b0;
    tick(); tick();
    txn_done = 1'b1;
    wait_resp(10, cyc);
    chk("t6_resp_after", 64'(resp_valid), 64'h2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_txn_scheduler.md
Name: axi_burst_txn_scheduler

Overview:
- Shares the single M00_AXI burst master engine between NUM_REQ requesters.
- Arbitrates round-robin, launches one transaction at a time with a 1-cycle init pulse, then waits for completion.
- On completion (or watchdog timeout) it returns status to the requester that issued the transaction.
- Sits between the requesters (command logic, register-driven tests) and the engine's INIT_AXI_TXN / TXN_DONE / ERROR interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, width of the transaction base address.
- TIMEOUT_CYCLES, 4096, number of WAIT cycles before a forced timeout completion (at least 16).
- INIT_PULSE_W, 1, width of the init pulse in cycles (1..4).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_wr  in  NUM_REQ  1 = write-then-check transaction, 0 = read-only.
- req_addr  in  NUM_REQ*ADDR_W  packed base addresses; requester i uses [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- txn_init  out  1  init pulse to the master engine.
- txn_addr  out  ADDR_W  base address held for the engine.
- txn_wr  out  1  transaction type held for the engine.
- txn_done  in  1  engine done level; stays high until the next init.
- txn_error  in  1  engine error, valid when txn_done rises.
- resp_valid  out  NUM_REQ  one-hot 1-cycle completion strobe.
- resp_error  out  1  error qualifier for resp_valid.
- resp_timeout  out  1  timeout qualifier for resp_valid.
- busy  out  1  high in every state except IDLE.
- cur_grant  out  $clog2(NUM_REQ)  index of the active requester.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; done_q 0; timeout counter 0.
- Reset asserted mid-transaction:
  - State returns to IDLE with no response issued.
  - txn_init is forced low on the same edge.
- State machine:
  - IDLE: if any req_valid is set, go to ARB.
  - ARB (1 cycle):
    - Grant the first set bit found scanning from rr_ptr upward with wrap-around.
    - Pulse req_ready[g] for this one cycle; latch req_addr[g] and req_wr[g] into txn_addr and txn_wr; set cur_grant = g.
    - Set rr_ptr = (g+1) mod NUM_REQ; go to LAUNCH.
    - If req_valid has dropped to all-zero in this cycle, return to IDLE with no grant.
  - LAUNCH: hold txn_init high for INIT_PULSE_W cycles, then go to WAIT with the counter cleared.
  - WAIT:
    - done_q is the registered copy of txn_done.
    - Completion = txn_done & ~done_q, qualified only from the second WAIT cycle on. This masks a stale high level left over from the previous transaction.
    - On completion: capture txn_error, go to RESP.
    - Otherwise the counter increments; at TIMEOUT_CYCLES-1 go to RESP with error=1 and timeout=1.
    - If completion and timeout occur on the same cycle, completion wins (timeout=0).
  - RESP (1 cycle):
    - Assert resp_valid[cur_grant] together with resp_error and resp_timeout.
    - Go to ARB if any req_valid is set, otherwise IDLE.
- Throughput and latency:
  - Back-to-back requests cost 3 + INIT_PULSE_W cycles of overhead per transaction, plus the engine latency.
  - Latency from req_valid to txn_init rising is 2 cycles from IDLE.
- Arbitration fairness:
  - A requester that drops req_valid before it is granted is skipped.
  - A requester is never granted twice in a row while another req_valid is set.
- Output timing:
  - txn_addr and txn_wr remain stable from ARB until the next ARB.
  - txn_init and resp_valid are glitch-free registered outputs.
- Stale engine completion: txn_done rising outside WAIT is ignored (done_q still tracks it).

Decomposition:
- Package axi_sched_pkg:
  - State enum sched_state_t {IDLE, ARB, LAUNCH, WAIT, RESP}.
  - Function rr_pick(req, ptr) returning index and found flag.
  - Localparam CNT_W = $clog2(TIMEOUT_CYCLES).
- Sub-module rr_arbiter_comb: purely combinational round-robin picker (req vector, ptr -> one-hot grant plus index); reusable by the S00 register block.
- FSM, counter and edge detector stay in the top module.

Test Plan:
- Single requester: req_valid=4'b0100, addr=0x40000000, wr=1. Engine asserts done 20 cycles after init, error=0. Expect:
  - req_ready=4'b0100 one cycle after req_valid.
  - txn_init high exactly 1 cycle, txn_addr=0x40000000.
  - resp_valid=4'b0100 with error=0, timeout=0.
- Contention: all four req_valid held high for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3 and no repeated index.
- Engine error: txn_error=1 at the done rise. Expect resp_error=1, resp_timeout=0 for the granted requester.
- Timeout: with TIMEOUT_CYCLES=16, the engine never asserts done. Expect resp_valid 16 cycles after WAIT entry with error=1, timeout=1; busy then drops if no requests remain.
- Stale done: txn_done left high from the previous transaction, new request issued. Expect no completion until txn_done falls and rises again.
- Reset mid-WAIT: assert ARESET for 1 cycle. Expect all outputs 0 on the next edge, no resp_valid, and the next grant to start from requester 0.
